// File: rtl/line_scaler.sv
// line_scaler: double-buffered line store that replays 160-pixel RGB332 source
// lines scaled x4 horizontally and x2 vertically into the 720x480 active window.
// Ports:
//   clk, reset_n            pixel clock, asynchronous active-low reset
//   in_image, in_vblank     raster flags from hdmi
//   wr_valid, wr_data       source pixel stream (RGB332), wr_ready back-pressure
//   line_request            pulse: a line swap succeeded, writer may send next line
//   frame_start             pulse: rising edge of in_vblank seen
//   underrun                pulse: swap was due but the write bank was incomplete
//   red, green, blue        registered 8-bit expanded colour
module line_scaler #(
    parameter int unsigned SRC_WIDTH    = 160,
    parameter int unsigned SRC_HEIGHT   = 240,
    parameter int unsigned H_SCALE      = 4,
    parameter int unsigned V_SCALE      = 2,
    parameter int unsigned H_OFFSET     = 40,
    parameter logic [7:0]  BORDER_COLOR = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_image,
    input  logic       in_vblank,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       line_request,
    output logic       frame_start,
    output logic       underrun,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    localparam int unsigned XW     = (SRC_WIDTH > 1) ? $clog2(SRC_WIDTH) : 1;
    localparam int unsigned CW     = $clog2(SRC_WIDTH + 1);
    localparam int unsigned YW     = $clog2(SRC_HEIGHT + 1);
    localparam int unsigned HW     = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
    localparam int unsigned VW     = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned ROW_W  = 9;
    localparam int unsigned WIN_LO = H_OFFSET;
    localparam int unsigned WIN_HI = H_OFFSET + SRC_WIDTH * H_SCALE;

    logic [7:0]       mem [2][SRC_WIDTH];
    logic             rd_bank;
    logic [CW-1:0]    wr_count;
    logic             img_q;
    logic             vb_q;
    logic [COL_W-1:0] col;
    logic [HW-1:0]    hrep;
    logic [CW-1:0]    src_x;
    logic [ROW_W-1:0] row;
    logic [VW-1:0]    vrep;
    logic [YW-1:0]    src_y;
    logic [7:0]       rd_q;
    logic             show_q;

    logic img_fall;
    logic vb_rise;
    logic vb_fall;
    logic row_ok;
    logic in_win;
    logic line_full;
    logic wr_fire;
    logic swap_due;
    logic [7:0] pix;

    // Edge detection and window/eligibility decode
    assign img_fall  = img_q & ~in_image;
    assign vb_rise   = in_vblank & ~vb_q;
    assign vb_fall   = vb_q & ~in_vblank;
    assign row_ok    = (src_y < YW'(SRC_HEIGHT));
    assign in_win    = in_image && (col >= COL_W'(WIN_LO)) && (col < COL_W'(WIN_HI));
    assign line_full = (wr_count == CW'(SRC_WIDTH));
    assign wr_ready  = ~line_full;
    assign wr_fire   = wr_valid & wr_ready;
    assign swap_due  = vb_fall | (img_fall & (vrep == VW'(V_SCALE - 1)) & row_ok);

    // Bank control: frame restart discards a partial line and wins over a swap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            img_q        <= 1'b0;
            vb_q         <= 1'b0;
            rd_bank      <= 1'b0;
            wr_count     <= '0;
            line_request <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            img_q        <= in_image;
            vb_q         <= in_vblank;
            line_request <= 1'b0;
            underrun     <= 1'b0;
            frame_start  <= vb_rise;
            if (vb_rise) begin
                wr_count <= '0;
            end else if (swap_due && line_full) begin
                rd_bank      <= ~rd_bank;
                wr_count     <= '0;
                line_request <= 1'b1;
            end else begin
                if (swap_due) underrun <= 1'b1;
                if (wr_fire)  wr_count <= wr_count + CW'(1);
            end
        end
    end

    // Horizontal position: hrep sub-counter steps src_x every H_SCALE columns
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col   <= '0;
            hrep  <= '0;
            src_x <= '0;
        end else if (!in_image) begin
            col   <= '0;
            hrep  <= '0;
            src_x <= '0;
        end else begin
            col <= col + COL_W'(1);
            if (in_win) begin
                if (hrep == HW'(H_SCALE - 1)) begin
                    hrep  <= '0;
                    src_x <= src_x + CW'(1);
                end else begin
                    hrep <= hrep + HW'(1);
                end
            end
        end
    end

    // Vertical position: advances at end of each active line, src_y saturates
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row   <= '0;
            vrep  <= '0;
            src_y <= '0;
        end else if (in_vblank) begin
            row   <= '0;
            vrep  <= '0;
            src_y <= '0;
        end else if (img_fall) begin
            row <= row + ROW_W'(1);
            if (vrep == VW'(V_SCALE - 1)) begin
                vrep <= '0;
                if (row_ok) src_y <= src_y + YW'(1);
            end else begin
                vrep <= vrep + VW'(1);
            end
        end
    end

    // Line RAM: stream side writes the idle bank, display side reads rd_bank
    always_ff @(posedge clk) begin
        if (wr_fire) mem[~rd_bank][XW'(wr_count)] <= wr_data;
        if (in_win)  rd_q <= mem[rd_bank][XW'(src_x)];
    end

    // Output stage: border select and RGB332 bit-replication expansion
    assign pix = show_q ? rd_q : BORDER_COLOR;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            show_q <= 1'b0;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else begin
            show_q <= in_win & row_ok;
            red    <= {pix[7:5], pix[7:5], pix[7:6]};
            green  <= {pix[4:2], pix[4:2], pix[4:3]};
            blue   <= {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
        end
    end

endmodule

// File: tb/tb_line_scaler.sv
// Directed bench for line_scaler: drives a shortened raster (720-column active
// lines, short blanking, short filler lines) plus a pixel stream, and compares
// colour per column, handshake and event pulses against a small line model.
module tb_line_scaler;

    localparam int HB = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_image;
    logic       in_vblank;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       line_request;
    logic       frame_start;
    logic       underrun;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    line_scaler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_image     (in_image),
        .in_vblank    (in_vblank),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .line_request (line_request),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int lr_cnt   = 0;
    int us_cnt   = 0;
    int fs_cnt   = 0;
    int lr0, us0, fs0;

    logic [7:0] push_q[$];
    logic [7:0] disp [160];
    logic [7:0] la [160];
    logic [7:0] lb [160];
    logic [7:0] lc [160];
    logic [7:0] ld [160];
    logic [7:0] le [160];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] expand(input logic [7:0] d);
        return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3],
                d[1:0], d[1:0], d[1:0], d[1:0]};
    endfunction

    // Expected colour of a column given the line the model believes is shown
    function automatic logic [23:0] exp_px(input int c, input bit border);
        logic [7:0] d;
        if (border || c < 40 || c >= 680) d = 8'h00;
        else                               d = disp[(c - 40) / 4];
        return expand(d);
    endfunction

    // One clock: drive raster + stream, advance, then tally event pulses
    task automatic cyc(input logic img, input logic vb);
        logic acc;
        in_image  = img;
        in_vblank = vb;
        if (push_q.size() > 0) begin
            wr_valid = 1'b1;
            wr_data  = push_q[0];
        end else begin
            wr_valid = 1'b0;
            wr_data  = 8'h00;
        end
        acc = wr_valid && wr_ready;
        @(posedge clk);
        #1;
        if (acc) push_q.delete(0);
        if (line_request) lr_cnt++;
        if (underrun)     us_cnt++;
        if (frame_start)  fs_cnt++;
    endtask

    // mode 0: no colour checks, 1: check against disp, 2: expect border
    task automatic run_line(input int nact, input int mode, input string tag);
        for (int i = 0; i < nact + HB; i++) begin
            cyc(i < nact, 1'b0);
            if (mode != 0 && i >= 1 && i <= nact)
                check_eq($sformatf("%s_col%0d", tag, i - 1), {8'h00, red, green, blue},
                         {8'h00, exp_px(i - 1, mode == 2)});
        end
    endtask

    task automatic push_n(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) push_q.push_back(v);
    endtask

    task automatic pulses(input string tag, input int lr_exp, input int us_exp);
        check_eq({tag, "_line_request"}, 32'(lr_cnt - lr0), 32'(lr_exp));
        check_eq({tag, "_underrun"}, 32'(us_cnt - us0), 32'(us_exp));
        lr0 = lr_cnt;
        us0 = us_cnt;
    endtask

    // Vertical blank: frame start, deliver line 0, then swap on the falling edge
    task automatic frame_begin(input string tag, input logic [7:0] ln [160]);
        bit seen;
        seen = 1'b0;
        fs0  = fs_cnt;
        cyc(1'b0, 1'b1);
        check_eq({tag, "_frame_start"}, 32'(frame_start), 32'd1);
        check_eq({tag, "_ready_after_fs"}, 32'(wr_ready), 32'd1);
        for (int i = 0; i < 160; i++) push_q.push_back(ln[i]);
        for (int k = 0; k < 199; k++) begin
            cyc(1'b0, 1'b1);
            if (!seen && push_q.size() == 0) begin
                seen = 1'b1;
                check_eq({tag, "_ready_full"}, 32'(wr_ready), 32'd0);
            end
        end
        check_eq({tag, "_beats_left"}, 32'(push_q.size()), 32'd0);
        check_eq({tag, "_fs_count"}, 32'(fs_cnt - fs0), 32'd1);
        push_q.delete();
        lr0 = lr_cnt;
        us0 = us_cnt;
        cyc(1'b0, 1'b0);
        check_eq({tag, "_swap_lr"}, 32'(line_request), 32'd1);
        check_eq({tag, "_ready_after_swap"}, 32'(wr_ready), 32'd1);
        pulses({tag, "_vfall"}, 1, 0);
        disp = ln;
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 160; i++) begin
            la[i] = 8'hE0;
            lb[i] = 8'(i);
            lc[i] = 8'h1C;
            ld[i] = 8'(i * 7 + 3);
            le[i] = 8'(255 - i);
        end
        reset_n   = 1'b0;
        in_image  = 1'b0;
        in_vblank = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("rst_rgb", {8'h00, red, green, blue}, 32'h0);
        check_eq("rst_line_request", 32'(line_request), 32'd0);
        check_eq("rst_frame_start", 32'(frame_start), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0);
        check_eq("idle_no_fs", 32'(fs_cnt), 32'd0);

        // Frame 1: fill/swap, vertical and horizontal scaling, underrun recovery
        frame_begin("f1", la);
        push_q.delete();
        for (int i = 0; i < 160; i++) push_q.push_back(lb[i]);
        run_line(720, 1, "f1r0");
        pulses("f1r0", 0, 0);
        run_line(720, 1, "f1r1");
        pulses("f1r1", 1, 0);
        disp = lb;
        push_n(8'h1C, 100);
        run_line(720, 1, "f1r2");
        pulses("f1r2", 0, 0);
        run_line(720, 1, "f1r3");
        pulses("f1r3", 0, 1);
        push_n(8'h1C, 60);
        run_line(720, 1, "f1r4");
        pulses("f1r4", 0, 0);
        run_line(720, 1, "f1r5");
        pulses("f1r5", 1, 0);
        disp = lc;
        push_n(8'h03, 50);
        run_line(720, 1, "f1r6");
        pulses("f1r6", 0, 0);

        // Frame 2: partial line discarded at frame start, then reset mid-line
        frame_begin("f2", ld);
        run_line(720, 1, "f2r0");
        pulses("f2r0", 0, 0);
        push_n(8'h55, 160);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b0);
            if (i >= 1)
                check_eq($sformatf("f2r1_col%0d", i - 1), {8'h00, red, green, blue},
                         {8'h00, exp_px(i - 1, 1'b0)});
        end
        check_eq("pre_reset_ready", 32'(wr_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
        check_eq("mid_rst_rgb", {8'h00, red, green, blue}, 32'h0);
        check_eq("mid_rst_pulses", {29'h0, line_request, frame_start, underrun}, 32'h0);
        push_q.delete();
        in_image = 1'b0;
        wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        lr0 = lr_cnt;
        us0 = us_cnt;
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0);
        pulses("post_rst", 0, 0);

        // Frame 3: normal start after reset, then border rows past SRC_HEIGHT
        frame_begin("f3", le);
        run_line(720, 1, "f3r0");
        pulses("f3r0", 0, 0);
        run_line(720, 1, "f3r1");
        pulses("f3r1", 0, 1);
        for (int r = 2; r < 479; r++) run_line(2, 0, "");
        lr0 = lr_cnt;
        us0 = us_cnt;
        run_line(2, 0, "");
        pulses("f3r479", 0, 1);
        run_line(720, 2, "f3r480");
        run_line(2, 0, "");
        pulses("f3r481", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
